// File: rtl/pulse_peak_detector_pkg.sv
// Shared settings for the pulse processing chain: sizes, peak-detector state
// encoding and the event record carried from the detector to the readout FIFO.
package package_settings_v2;

    localparam int SIZE_FILTER_DATA = 13;
    localparam int SIZE_TIMESTAMP   = 16;
    localparam int PEAK_HOLDOFF     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        HOLD = 2'd3
    } peak_state_t;

    // Default-width event record; the detector re-declares it when its widths are overridden.
    typedef struct packed {
        logic signed [SIZE_FILTER_DATA+2:0] amp;
        logic [SIZE_TIMESTAMP-1:0]          tstamp;
        logic                               pileup;
    } peak_event_t;

endpackage

// File: rtl/pulse_peak_detector_event_fifo.sv
// First-word-fall-through event buffer: head entry is visible on head_o whenever
// the FIFO is non-empty. A push while full is accepted only if a pop happens alongside it.
module event_fifo
    import package_settings_v2::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = peak_event_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  T     push_data_i,
    input  logic pop_i,
    output T     head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the occupancy count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_comb begin
        head_o = '0;
        if (!empty_o) head_o = mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/pulse_peak_detector.sv
// Peak detector behind the trapezoidal filter: one (amplitude, timestamp) event per
// threshold-crossing pulse. Define PEAK_PILEUP_REJECT_EN to flag re-rising pulses.
module pulse_peak_detector
    import package_settings_v2::*;
#(
    parameter int DATA_W     = SIZE_FILTER_DATA + 3,
    parameter int TS_W       = SIZE_TIMESTAMP,
    parameter int HOLDOFF    = PEAK_HOLDOFF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] filt_data,
    input  logic                     filt_valid,
    input  logic signed [DATA_W-1:0] threshold,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic signed [DATA_W-1:0] evt_amp,
    output logic [TS_W-1:0]          evt_time,
    output logic                     evt_pileup,
    output logic                     fifo_full,
    output logic [7:0]               drop_cnt
);

    localparam int HOLD_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

    typedef struct packed {
        logic signed [DATA_W-1:0] amp;
        logic [TS_W-1:0]          tstamp;
        logic                     pileup;
    } evt_t;

    peak_state_t              state_q;
    logic [TS_W-1:0]          ts_q;
    logic signed [DATA_W-1:0] max_q;
    logic [TS_W-1:0]          max_ts_q;
    logic [HOLD_W-1:0]        hold_q;
    logic [7:0]               drop_cnt_q, drop_cnt_d;
`ifdef PEAK_PILEUP_REJECT_EN
    logic signed [DATA_W-1:0] prev_q;
    logic                     pile_q;
`endif

    logic above;
    logic push;
    evt_t push_evt;
    evt_t head;
    logic fifo_empty;
    logic fifo_full_w;
    logic pop;
    logic drop;

    assign above = (filt_data > threshold);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ts_q     <= '0;
            max_q    <= '0;
            max_ts_q <= '0;
            hold_q   <= '0;
`ifdef PEAK_PILEUP_REJECT_EN
            prev_q   <= '0;
            pile_q   <= 1'b0;
`endif
        end else if (filt_valid) begin
            ts_q <= ts_q + TS_W'(1);
            case (state_q)
                IDLE: begin
                    if (above) begin
                        state_q  <= RISE;
                        max_q    <= filt_data;
                        max_ts_q <= ts_q;
`ifdef PEAK_PILEUP_REJECT_EN
                        pile_q   <= 1'b0;
`endif
                    end
                end
                RISE: begin
                    // Equal samples move the timestamp: the last sample of a plateau is the peak.
                    if (filt_data >= max_q) begin
                        max_q    <= filt_data;
                        max_ts_q <= ts_q;
                    end else begin
                        state_q <= FALL;
`ifdef PEAK_PILEUP_REJECT_EN
                        prev_q  <= filt_data;
`endif
                    end
                end
                FALL: begin
                    if (!above) begin
                        if (HOLDOFF == 0) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= HOLD;
                            hold_q  <= HOLD_W'(HOLDOFF);
                        end
                    end
`ifdef PEAK_PILEUP_REJECT_EN
                    else begin
                        if (filt_data > prev_q) pile_q <= 1'b1;
                        prev_q <= filt_data;
                    end
`endif
                end
                HOLD: begin
                    hold_q <= hold_q - HOLD_W'(1);
                    if (hold_q == HOLD_W'(1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        push_evt.amp    = max_q;
        push_evt.tstamp = max_ts_q;
        push_evt.pileup = 1'b0;
`ifdef PEAK_PILEUP_REJECT_EN
        push_evt.pileup = pile_q;
        push = filt_valid && (state_q == FALL) && !above;
`else
        push = filt_valid && (state_q == RISE) && (filt_data < max_q);
`endif
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (evt_t)
    ) u_event_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_evt),
        .pop_i       (evt_ready),
        .head_o      (head),
        .full_o      (fifo_full_w),
        .empty_o     (fifo_empty)
    );

    assign pop  = !fifo_empty && evt_ready;
    assign drop = push && fifo_full_w && !pop;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign evt_valid  = !fifo_empty;
    assign evt_amp    = head.amp;
    assign evt_time   = head.tstamp;
    assign evt_pileup = head.pileup;
    assign fifo_full  = fifo_full_w;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Self-checking bench for pulse_peak_detector: directed pulses with literal expectations,
// then randomized traffic against a sample-history model. Honours PEAK_PILEUP_REJECT_EN.
module tb_pulse_peak_detector;

    localparam int DW      = 16;
    localparam int TW      = 8;
    localparam int HO      = 8;
    localparam int DEPTH   = 4;
    localparam int TS_MOD  = 1 << TW;
`ifdef PEAK_PILEUP_REJECT_EN
    localparam bit PILE_EN = 1'b1;
`else
    localparam bit PILE_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic signed [DW-1:0] filt_data;
    logic                 filt_valid;
    logic signed [DW-1:0] threshold;
    logic                 evt_valid;
    logic                 evt_ready;
    logic signed [DW-1:0] evt_amp;
    logic [TW-1:0]        evt_time;
    logic                 evt_pileup;
    logic                 fifo_full;
    logic [7:0]           drop_cnt;

    pulse_peak_detector #(
        .DATA_W     (DW),
        .TS_W       (TW),
        .HOLDOFF    (HO),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .filt_data  (filt_data),
        .filt_valid (filt_valid),
        .threshold  (threshold),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_amp    (evt_amp),
        .evt_time   (evt_time),
        .evt_pileup (evt_pileup),
        .fifo_full  (fifo_full),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int amp;
        int tstamp;
        bit pileup;
    } mevt_t;

    mevt_t m_fifo[$];
    int    m_drop;
    int    m_ts;
    int    m_climb[$];      // samples of the current rising edge (non-decreasing)
    int    m_climb_ts;
    int    m_desc[$];       // samples seen after the peak while still above threshold
    int    m_ignore;
    int    m_peak_amp, m_peak_ts;
    int    m_s, m_th;
    bit    m_push, m_pop, m_pile;
    mevt_t m_ev;

    always @(posedge clk) begin
        m_push = 1'b0;
        m_pop  = (m_fifo.size() > 0) && evt_ready;
        if (reset) begin
            m_fifo.delete();
            m_climb.delete();
            m_desc.delete();
            m_drop   = 0;
            m_ts     = 0;
            m_ignore = 0;
        end else begin
            if (filt_valid) begin
                m_s  = int'(filt_data);
                m_th = int'(threshold);
                if (m_ignore > 0) begin
                    m_ignore--;
                end else if (m_climb.size() > 0) begin
                    if (m_s >= m_climb[m_climb.size()-1]) begin
                        m_climb.push_back(m_s);
                    end else begin
                        m_peak_amp = m_climb[m_climb.size()-1];
                        m_peak_ts  = (m_climb_ts + m_climb.size() - 1) % TS_MOD;
                        m_climb.delete();
                        m_desc.delete();
                        m_desc.push_back(m_s);
                        if (!PILE_EN) begin
                            m_push      = 1'b1;
                            m_ev.amp    = m_peak_amp;
                            m_ev.tstamp = m_peak_ts;
                            m_ev.pileup = 1'b0;
                        end
                    end
                end else if (m_desc.size() > 0) begin
                    if (m_s <= m_th) begin
                        m_pile = 1'b0;
                        for (int i = 1; i < m_desc.size(); i++)
                            if (m_desc[i] > m_desc[i-1]) m_pile = 1'b1;
                        if (PILE_EN) begin
                            m_push      = 1'b1;
                            m_ev.amp    = m_peak_amp;
                            m_ev.tstamp = m_peak_ts;
                            m_ev.pileup = m_pile;
                        end
                        m_desc.delete();
                        m_ignore = HO;
                    end else begin
                        m_desc.push_back(m_s);
                    end
                end else if (m_s > m_th) begin
                    m_climb.push_back(m_s);
                    m_climb_ts = m_ts;
                end
                m_ts = (m_ts + 1) % TS_MOD;
            end
            if (m_pop) void'(m_fifo.pop_front());
            if (m_push) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(m_ev);
                else if (m_drop < 255)     m_drop++;
            end
        end
    end

    // Compare process: every cycle, half a period after the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("evt_valid", int'(evt_valid), int'(m_fifo.size() > 0));
            check("fifo_full", int'(fifo_full), int'(m_fifo.size() == DEPTH));
            check("drop_cnt", int'(drop_cnt), m_drop);
            if (m_fifo.size() > 0) begin
                check("evt_amp", int'(evt_amp), m_fifo[0].amp);
                check("evt_time", int'(evt_time), m_fifo[0].tstamp);
                check("evt_pileup", int'(evt_pileup), int'(m_fifo[0].pileup));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input int d, input bit rdy);
        filt_valid = v;
        filt_data  = DW'(d);
        evt_ready  = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic idle_samples(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b1, 0, rdy);
    endtask

    // Short pulse: 0, a, 150, 50 then the holdoff window.
    task automatic short_pulse(input int a);
        step(1'b1, 0, 1'b0);
        step(1'b1, a, 1'b0);
        step(1'b1, 150, 1'b0);
        step(1'b1, 50, 1'b0);
        idle_samples(HO, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        filt_valid = 1'b0;
        filt_data  = '0;
        threshold  = DW'(100);
        evt_ready  = 1'b0;
        do_reset();
        chk_en = 1'b1;

        // Reset values
        check("rst_evt_valid", int'(evt_valid), 0);
        check("rst_evt_amp", int'(evt_amp), 0);
        check("rst_evt_time", int'(evt_time), 0);
        check("rst_evt_pileup", int'(evt_pileup), 0);
        check("rst_fifo_full", int'(fifo_full), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);

        // Basic pulse and commit latency
        step(1'b1, 0, 1'b0);
        step(1'b1, 50, 1'b0);
        step(1'b1, 150, 1'b0);
        step(1'b1, 300, 1'b0);
        check("basic_valid_before_peak_known", int'(evt_valid), 0);
        step(1'b1, 250, 1'b0);
        check("basic_valid_after_250", int'(evt_valid), PILE_EN ? 0 : 1);
        step(1'b1, 80, 1'b0);
        check("basic_valid_after_80", int'(evt_valid), 1);
        check("basic_amp", int'(evt_amp), 300);
        check("basic_time", int'(evt_time), 3);
        check("basic_pileup", int'(evt_pileup), 0);
        step(1'b1, 0, 1'b1);
        check("basic_popped", int'(evt_valid), 0);

        // Plateau: later equal sample wins
        do_reset();
        step(1'b1, 150, 1'b0);
        step(1'b1, 200, 1'b0);
        step(1'b1, 200, 1'b0);
        step(1'b1, 120, 1'b0);
        step(1'b1, 0, 1'b0);
        check("plateau_amp", int'(evt_amp), 200);
        check("plateau_time", int'(evt_time), 2);

        // Overflow: five pulses into a depth-4 FIFO, then drain in order
        do_reset();
        for (int p = 0; p < 5; p++) short_pulse(200 + 10 * p);
        check("ovf_full", int'(fifo_full), 1);
        check("ovf_drop", int'(drop_cnt), 1);
        for (int p = 0; p < 4; p++) begin
            check("ovf_order_amp", int'(evt_amp), 200 + 10 * p);
            step(1'b0, 0, 1'b1);
        end
        check("ovf_drained", int'(evt_valid), 0);

        // Pile-up: re-rise while still above threshold
        do_reset();
        step(1'b1, 150, 1'b0);
        step(1'b1, 300, 1'b0);
        step(1'b1, 200, 1'b0);
        step(1'b1, 260, 1'b0);
        step(1'b1, 90, 1'b0);
        idle_samples(HO + 3, 1'b0);
        check("pile_amp", int'(evt_amp), 300);
        check("pile_time", int'(evt_time), 1);
        check("pile_flag", int'(evt_pileup), PILE_EN ? 1 : 0);
        step(1'b1, 0, 1'b1);
        check("pile_single_event", int'(evt_valid), 0);

        // Reset during RISE with two events buffered
        do_reset();
        short_pulse(220);
        short_pulse(230);
        step(1'b1, 0, 1'b0);
        step(1'b1, 150, 1'b0);
        step(1'b1, 300, 1'b0);
        check("midrst_buffered", int'(evt_valid), 1);
        do_reset();
        check("midrst_valid", int'(evt_valid), 0);
        check("midrst_drop", int'(drop_cnt), 0);
        step(1'b1, 0, 1'b0);
        step(1'b1, 150, 1'b0);
        step(1'b1, 300, 1'b0);
        step(1'b1, 200, 1'b0);
        step(1'b1, 0, 1'b0);
        check("midrst_amp", int'(evt_amp), 300);
        check("midrst_time", int'(evt_time), 2);

        // Holdoff window and negative samples
        do_reset();
        step(1'b1, -50, 1'b0);
        step(1'b1, -50, 1'b0);
        step(1'b1, 150, 1'b0);
        step(1'b1, 300, 1'b0);
        step(1'b1, 200, 1'b0);
        step(1'b1, 50, 1'b0);
        step(1'b1, 0, 1'b0);
        step(1'b1, 250, 1'b0);
        step(1'b1, 260, 1'b0);
        idle_samples(HO - 3, 1'b0);
        step(1'b1, 180, 1'b0);
        step(1'b1, 120, 1'b0);
        step(1'b1, 0, 1'b0);
        check("hold_first_amp", int'(evt_amp), 300);
        check("hold_first_time", int'(evt_time), 3);
        step(1'b0, 0, 1'b1);
        check("hold_second_amp", int'(evt_amp), 180);
        check("hold_second_time", int'(evt_time), 14);
        step(1'b0, 0, 1'b1);
        check("hold_no_third", int'(evt_valid), 0);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0:       threshold = DW'(100);
                    1:       threshold = DW'(-20);
                    default: threshold = DW'(0);
                endcase
            end
            reset = ($urandom_range(0, 499) == 0);
            step($urandom_range(0, 99) < 85,
                 int'($urandom_range(0, 600)) - 200,
                 $urandom_range(0, 99) < 45);
        end
        reset = 1'b0;
        idle_samples(20, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_peak_detector.md
# pulse_peak_detector

Downstream of the trapezoidal shaping filter: consumes the filter's per-sample output, finds the peak of each pulse that crosses a programmable threshold, and emits one event (amplitude, timestamp) per pulse. Events are buffered in a small FIFO behind a valid/ready handshake toward the readout logic. An optional pile-up check flags pulses that re-rise before returning below threshold.

## Interface
- `DATA_W`, default `SIZE_FILTER_DATA+3`: filter sample width, signed two's complement.
- `TS_W`, default 16: timestamp width.
- `HOLDOFF`, default 8: valid samples ignored after a pulse falls below threshold.
- `FIFO_DEPTH`, default 4: event buffer depth, power of two, ≥2.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `filt_data`  in  DATA_W: filter output sample, signed.
- `filt_valid`  in  1: `filt_data` valid this cycle. State and timestamp advance only on valid cycles.
- `threshold`  in  DATA_W: signed trigger level; quasi-static, sampled every valid cycle.
- `evt_valid`  out  1: FIFO non-empty.
- `evt_ready`  in  1: consumer accepts the head event.
- `evt_amp`  out  DATA_W: peak amplitude of the head event.
- `evt_time`  out  TS_W: timestamp of the peak sample.
- `evt_pileup`  out  1: pile-up flag of the head event; constant 0 without the macro.
- `fifo_full`  out  1: FIFO holds FIFO_DEPTH events.
- `drop_cnt`  out  8: events lost to a full FIFO, saturating at 255.

## Operation
- Timestamp counter `ts`:
  - Increments on every valid sample and wraps modulo 2^TS_W.
  - The first valid sample after reset carries `ts` = 0.
- All compares are signed. "Above" means `filt_data > threshold` (strict).
- States and transitions:
  - IDLE: a valid sample above threshold moves to RISE; latch `max` = sample, `max_ts` = `ts`.
  - RISE, on each valid sample:
    - sample ≥ `max`: update `max` and `max_ts`. On equal samples, the later timestamp wins.
    - sample < `max`: the peak is found; go to FALL.
  - FALL: wait for a valid sample ≤ threshold, then go to HOLD and load the holdoff counter with HOLDOFF.
  - HOLD: decrement on each valid sample; at 0 return to IDLE. Threshold crossings during HOLD are ignored. HOLDOFF = 0 returns directly to IDLE.
- Event commit:
  - Without the macro: push at the RISE→FALL transition.
  - With the macro: push at the FALL→HOLD transition.
- FIFO:
  - First-word-fall-through. `evt_*` outputs are the registered head entry.
  - Pop when `evt_valid && evt_ready`.
  - Push while full and no pop in the same cycle: the event is discarded and `drop_cnt` increments, saturating.
  - Push and pop in the same cycle while full: both succeed, and the count stays at FIFO_DEPTH.
  - Push into an empty FIFO: the event is visible in the next cycle.
- `filt_valid` = 0 freezes the FSM, `ts`, and the holdoff counter. The FIFO still pops.

## Timing
- Reset values, effective on the edge where `reset` = 1: state IDLE, `ts` = 0, FIFO empty, `evt_valid` = 0, `evt_amp` = 0, `evt_time` = 0, `evt_pileup` = 0, `fifo_full` = 0, `drop_cnt` = 0.
- Reset mid-pulse discards the partial event and all buffered events.
- Latency without the macro: the edge that accepts the first sample below `max` writes the FIFO; `evt_valid` rises in the following cycle.
- Latency with the macro: same rule, counted from the edge that accepts the first sample ≤ threshold.
- `evt_amp`, `evt_time` and `evt_pileup` are stable while `evt_valid && !evt_ready`.
- Throughput: one pop per cycle. At most one push per valid sample.

## Configuration
- Macro: `PEAK_PILEUP_REJECT_EN`.
- Defined:
  - In FALL, track `prev` = last valid sample. A valid sample > `prev` sets a pile-up flag.
  - The event is pushed on exit from FALL with `evt_pileup` = flag.
  - The flag clears on entry to RISE.
- Undefined:
  - No `prev` tracking. `evt_pileup` is tied to 0.
  - The event is pushed at peak detection.

## Structure
- Add to `package_settings_v2`:
  - constants `SIZE_TIMESTAMP` = 16 and `PEAK_HOLDOFF` = 8;
  - enum `peak_state_t` {IDLE, RISE, FALL, HOLD};
  - packed struct `peak_event_t` {amp, time, pileup}.
- Sub-module `event_fifo`:
  - parameterised over depth and `peak_event_t`;
  - synchronous active-high reset;
  - provides push/pop/full/empty.

## Test plan
- Threshold 100; samples 0, 50, 150, 300, 250, 80, 0 (all valid) → one event: amp = 300, time = 3, pileup = 0.
  - Without the macro, `evt_valid` rises the cycle after sample 250 is accepted.
  - With the macro, it rises the cycle after sample 80 is accepted.
- Plateau 150, 200, 200, 120 → amp = 200, time = index of the second 200.
- Five pulses with `evt_ready` = 0, depth 4 → four events buffered, `fifo_full` = 1, `drop_cnt` = 1. Raising `evt_ready` pops them in order, one per cycle.
- With the macro: 150, 300, 200, 260, 90 → one event: amp = 300, pileup = 1. Without the macro: amp = 300, pileup = 0, and no second event is produced.
- `reset` asserted during RISE with 2 events buffered → next cycle `evt_valid` = 0, `drop_cnt` = 0, `ts` restarts at 0 on the next valid sample.
- Crossing within HOLDOFF samples after a fall is ignored; a crossing after HOLDOFF expires produces a new event. Negative samples (−50) never trigger with threshold 100.
